ahb_apb_bridge_ctrl: RTL and testbench
======================================

Name: ahb_apb_bridge_ctrl

Overview:
- AHB-slave to APB-master bridge controller; sits directly upstream of the APB interface stage.
- Accepts AHB transfers, decodes the address to one of three peripheral selects and sequences APB SETUP/ENABLE phases, driving Pwrite, Penable, Pselx, Paddr and Pwdata.
- Returns Prdata to the AHB side as Hrdata and stalls AHB with Hreadyout while the APB access completes.

Parameters:
- ADDR_W, 32, address width for Haddr and Paddr.
- DATA_W, 32, data width for Hwdata, Hrdata, Pwdata and Prdata.

Ports:
- Hclk  input  1  single clock; all state changes on rising edge.
- Hreset  input  1  asynchronous, active-high reset.
- Hwrite  input  1  AHB direction; 1=write, 0=read.
- Hreadyin  input  1  AHB bus ready; a transfer is accepted only when this is 1.
- Htrans  input  2  00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
- Haddr  input  ADDR_W  AHB address-phase address.
- Hwdata  input  DATA_W  AHB write data, valid in the data phase.
- Prdata  input  DATA_W  read data from the APB stage.
- Hreadyout  output  1  bridge ready; 0 stalls the AHB master.
- Hresp  output  2  00 OKAY, 01 ERROR.
- Hrdata  output  DATA_W  read data to AHB.
- Pwrite  output  1  APB direction.
- Penable  output  1  APB enable strobe.
- Pselx  output  3  one-hot APB slave select.
- Paddr  output  ADDR_W  APB address.
- Pwdata  output  DATA_W  APB write data.

Behaviour:
- valid = Hreadyin & Htrans[1]. IDLE and BUSY transfers are ignored.
- Address decode on Haddr[31:26]:
  - 0x80000000–0x83FFFFFF → Pselx 001
  - 0x84000000–0x87FFFFFF → Pselx 010
  - 0x88000000–0x8BFFFFFF → Pselx 100
  - anything else is unmapped.
- Accept point: in ST_IDLE, ST_WENABLE or ST_RENABLE, a valid mapped transfer latches Haddr, Hwrite and the decoded select into internal registers.
- FSM states: ST_IDLE, ST_WWAIT, ST_WSETUP, ST_WENABLE, ST_RSETUP, ST_RENABLE. All APB outputs are registered, with no combinational path from AHB inputs.
- ST_IDLE:
  - Hreadyout=1; all APB outputs deasserted.
  - valid & Hwrite → ST_WWAIT; valid & !Hwrite → ST_RSETUP; otherwise stay.
- ST_WWAIT:
  - Hreadyout=0; latch Hwdata.
  - → ST_WSETUP.
- ST_WSETUP:
  - Pselx=latched select, Paddr=latched address, Pwdata=latched data, Pwrite=1, Penable=0, Hreadyout=0.
  - → ST_WENABLE.
- ST_WENABLE:
  - Same APB values as ST_WSETUP but Penable=1; Hreadyout=1.
  - Next state decided as in ST_IDLE, so back-to-back transfers run with no idle cycle.
- ST_RSETUP:
  - Pselx/Paddr driven, Pwrite=0, Penable=0, Hreadyout=0.
  - → ST_RENABLE.
- ST_RENABLE:
  - Penable=1, Hreadyout=1, Hrdata=Prdata (combinational pass-through).
  - Next state as in ST_IDLE.
- Hrdata is 0 in all states other than ST_RENABLE.
- Latency from accept cycle to Hreadyout=1: write 3 cycles, read 2 cycles. Each APB access has exactly one SETUP cycle and one ENABLE cycle.
- Pwdata and Paddr hold their last values in ST_IDLE; Pselx and Penable are 0 in ST_IDLE.
- Reset: immediate asynchronous return to ST_IDLE, including mid-transfer; any in-flight APB access is abandoned.
  - Reset values: Hreadyout=1, Hresp=00, Hrdata=0, Pselx=000, Penable=0, Pwrite=0, Paddr=0, Pwdata=0.
- An unmapped valid transfer without the optional feature is treated as IDLE (no APB activity, OKAY).
- Hresp=00 in all states unless the optional feature is enabled.

Optional Feature:
- Macro: AHB_APB_ERRRESP_EN.
- Defined:
  - An unmapped valid transfer at an accept point moves to ST_ERR1 (Hreadyout=0, Hresp=01), then ST_ERR2 (Hreadyout=1, Hresp=01).
  - From ST_ERR2, next state is decided as in ST_IDLE.
  - No APB signals toggle during an error response.
- Undefined: no ERR states exist, Hresp is tied to 00, and unmapped transfers are silently ignored.

Test Plan:
- Reset asserted mid-ST_WSETUP → next sample shows Pselx=000, Penable=0, Hreadyout=1, FSM in ST_IDLE.
- Write NONSEQ Haddr=0x8000_0010, Hwdata=0xDEADBEEF →
  - cycle+2: Pselx=001, Pwrite=1, Penable=0, Paddr=0x80000010, Pwdata=0xDEADBEEF;
  - cycle+3: Penable=1, Hreadyout=1.
- Read Haddr=0x8400_0004 with Prdata=0x0000_00A5 → Pselx=010 in SETUP; in ENABLE Hrdata=0xA5 and Hreadyout=1; Hreadyout=0 exactly one cycle.
- Back-to-back read 0x88000000 issued during ST_WENABLE of a write → ST_RSETUP follows immediately with Pselx=100 and no idle cycle.
- Htrans=01 (BUSY) or Hreadyin=0 with a mapped address → no APB activity; Hreadyout stays 1.
- Unmapped Haddr=0x9000_0000:
  - with AHB_APB_ERRRESP_EN → Hresp=01 for two cycles, Hreadyout 0 then 1, Pselx=000 throughout;
  - without the macro → Hresp=00, no stall.

Source files
------------

// File: rtl/ahb_apb_bridge_ctrl.sv
// AHB-slave to APB-master bridge controller: decodes three peripheral windows and sequences
// APB SETUP/ENABLE phases. Define AHB_APB_ERRRESP_EN to answer unmapped transfers with ERROR.
module ahb_apb_bridge_ctrl #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              Hclk,
  input  logic              Hreset,
  input  logic              Hwrite,
  input  logic              Hreadyin,
  input  logic [1:0]        Htrans,
  input  logic [ADDR_W-1:0] Haddr,
  input  logic [DATA_W-1:0] Hwdata,
  input  logic [DATA_W-1:0] Prdata,
  output logic              Hreadyout,
  output logic [1:0]        Hresp,
  output logic [DATA_W-1:0] Hrdata,
  output logic              Pwrite,
  output logic              Penable,
  output logic [2:0]        Pselx,
  output logic [ADDR_W-1:0] Paddr,
  output logic [DATA_W-1:0] Pwdata
);

`ifdef AHB_APB_ERRRESP_EN
  typedef enum logic [2:0] {
    StIdle, StWWait, StWSetup, StWEnable, StRSetup, StREnable, StErr1, StErr2
  } state_e;
`else
  typedef enum logic [2:0] {
    StIdle, StWWait, StWSetup, StWEnable, StRSetup, StREnable
  } state_e;
`endif

  state_e              state_q, state_d;
  logic                valid;
  logic [2:0]          sel_dec;
  logic                accept;
  logic [ADDR_W-1:0]   addr_q;
  logic [2:0]          sel_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                unused_htrans;

  assign valid         = Hreadyin & Htrans[1];
  assign unused_htrans = Htrans[0];

  always_comb begin
    sel_dec = 3'b000;
    case (Haddr[31:26])
      6'b100000: sel_dec = 3'b001;
      6'b100001: sel_dec = 3'b010;
      6'b100010: sel_dec = 3'b100;
      default:   sel_dec = 3'b000;
    endcase
  end

  always_ff @(posedge Hclk or posedge Hreset) begin
    if (Hreset) begin
      state_q <= StIdle;
      addr_q  <= '0;
      sel_q   <= 3'b000;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        addr_q <= Haddr;
        sel_q  <= sel_dec;
      end
      // Write data arrives in the AHB data phase, one cycle after the address.
      if (state_q == StWWait) begin
        wdata_q <= Hwdata;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
`ifdef AHB_APB_ERRRESP_EN
      StIdle, StWEnable, StREnable, StErr2: begin
`else
      StIdle, StWEnable, StREnable: begin
`endif
        state_d = StIdle;
        if (valid && (sel_dec != 3'b000)) begin
          accept  = 1'b1;
          state_d = Hwrite ? StWWait : StRSetup;
        end
`ifdef AHB_APB_ERRRESP_EN
        else if (valid) begin
          state_d = StErr1;
        end
`endif
      end
      StWWait:  state_d = StWSetup;
      StWSetup: state_d = StWEnable;
      StRSetup: state_d = StREnable;
`ifdef AHB_APB_ERRRESP_EN
      StErr1:   state_d = StErr2;
`endif
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    Hreadyout = 1'b1;
    Hresp     = 2'b00;
    Hrdata    = '0;
    Pselx     = 3'b000;
    Penable   = 1'b0;
    Pwrite    = 1'b0;
    case (state_q)
      StWWait: Hreadyout = 1'b0;
      StWSetup: begin
        Hreadyout = 1'b0;
        Pselx     = sel_q;
        Pwrite    = 1'b1;
      end
      StWEnable: begin
        Pselx   = sel_q;
        Pwrite  = 1'b1;
        Penable = 1'b1;
      end
      StRSetup: begin
        Hreadyout = 1'b0;
        Pselx     = sel_q;
      end
      StREnable: begin
        Pselx   = sel_q;
        Penable = 1'b1;
        Hrdata  = Prdata;
      end
`ifdef AHB_APB_ERRRESP_EN
      StErr1: begin
        Hreadyout = 1'b0;
        Hresp     = 2'b01;
      end
      StErr2: Hresp = 2'b01;
`endif
      default: ;
    endcase
  end

  assign Paddr  = addr_q;
  assign Pwdata = wdata_q;

endmodule

// File: tb/tb_ahb_apb_bridge_ctrl.sv
// Bench for ahb_apb_bridge_ctrl: directed scenarios plus random traffic compared each cycle
// against a transaction-schedule model of the bridge.
module tb_ahb_apb_bridge_ctrl;

  logic        Hclk = 1'b0;
  logic        Hreset = 1'b1;
  logic        Hwrite = 1'b0;
  logic        Hreadyin = 1'b1;
  logic [1:0]  Htrans = 2'b00;
  logic [31:0] Haddr = '0;
  logic [31:0] Hwdata = '0;
  logic [31:0] Prdata = '0;
  logic        Hreadyout;
  logic [1:0]  Hresp;
  logic [31:0] Hrdata;
  logic        Pwrite;
  logic        Penable;
  logic [2:0]  Pselx;
  logic [31:0] Paddr;
  logic [31:0] Pwdata;

  always #5 Hclk = ~Hclk;

  ahb_apb_bridge_ctrl #(
    .ADDR_W(32),
    .DATA_W(32)
  ) u_dut (
    .Hclk      (Hclk),
    .Hreset    (Hreset),
    .Hwrite    (Hwrite),
    .Hreadyin  (Hreadyin),
    .Htrans    (Htrans),
    .Haddr     (Haddr),
    .Hwdata    (Hwdata),
    .Prdata    (Prdata),
    .Hreadyout (Hreadyout),
    .Hresp     (Hresp),
    .Hrdata    (Hrdata),
    .Pwrite    (Pwrite),
    .Penable   (Penable),
    .Pselx     (Pselx),
    .Paddr     (Paddr),
    .Pwdata    (Pwdata)
  );

  // One expected bus cycle; cap marks the data-phase cycle that carries write data.
  typedef struct packed {
    logic       rdy;
    logic [1:0] resp;
    logic [2:0] sel;
    logic       pen;
    logic       pwr;
    logic       rd;
    logic       cap;
  } rec_t;

  rec_t        plan[$];
  logic [31:0] m_paddr;
  logic [31:0] m_pwdata;
  int          n_checks = 0;
  int          n_fail = 0;

  function automatic rec_t mk(input logic rdy, input logic [1:0] resp, input logic [2:0] sel,
                              input logic pen, input logic pwr, input logic rd, input logic cap);
    rec_t r;
    r.rdy = rdy; r.resp = resp; r.sel = sel; r.pen = pen; r.pwr = pwr; r.rd = rd; r.cap = cap;
    return r;
  endfunction

  // Three 64 MB windows starting at 0x8000_0000.
  function automatic logic [2:0] decode(input logic [31:0] a);
    if (a >= 32'h8000_0000 && a < 32'h8C00_0000) begin
      return 3'b001 << ((a - 32'h8000_0000) >> 26);
    end
    return 3'b000;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    plan.delete();
    m_paddr  = '0;
    m_pwdata = '0;
  endtask

  // Called at a falling edge: drive inputs, check outputs against the model, advance one cycle.
  task automatic cycle(input logic [1:0] tr, input logic rin, input logic wr,
                       input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd);
    rec_t       cur;
    logic [2:0] s;
    Htrans = tr; Hreadyin = rin; Hwrite = wr; Haddr = a; Hwdata = wd; Prdata = rd;
    #1;
    cur = (plan.size() != 0) ? plan[0] : mk(1'b1, 2'b00, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("Hreadyout", {31'd0, Hreadyout}, {31'd0, cur.rdy});
    check_eq("Hresp", {30'd0, Hresp}, {30'd0, cur.resp});
    check_eq("Pselx", {29'd0, Pselx}, {29'd0, cur.sel});
    check_eq("Penable", {31'd0, Penable}, {31'd0, cur.pen});
    check_eq("Pwrite", {31'd0, Pwrite}, {31'd0, cur.pwr});
    check_eq("Hrdata", Hrdata, cur.rd ? rd : 32'd0);
    check_eq("Paddr", Paddr, m_paddr);
    check_eq("Pwdata", Pwdata, m_pwdata);
    if (plan.size() != 0) void'(plan.pop_front());
    if (cur.cap) m_pwdata = wd;
    s = decode(a);
    if (cur.rdy && rin && tr[1]) begin
      if (s != 3'b000) begin
        m_paddr = a;
        if (wr) begin
          plan.push_back(mk(1'b0, 2'b00, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1));
          plan.push_back(mk(1'b0, 2'b00, s, 1'b0, 1'b1, 1'b0, 1'b0));
          plan.push_back(mk(1'b1, 2'b00, s, 1'b1, 1'b1, 1'b0, 1'b0));
        end else begin
          plan.push_back(mk(1'b0, 2'b00, s, 1'b0, 1'b0, 1'b0, 1'b0));
          plan.push_back(mk(1'b1, 2'b00, s, 1'b1, 1'b0, 1'b1, 1'b0));
        end
      end
`ifdef AHB_APB_ERRRESP_EN
      else begin
        plan.push_back(mk(1'b0, 2'b01, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0));
        plan.push_back(mk(1'b1, 2'b01, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0));
      end
`endif
    end
    @(posedge Hclk);
    @(negedge Hclk);
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] base;
    model_reset();
    @(negedge Hclk);
    check_eq("rst_Hreadyout", {31'd0, Hreadyout}, 32'd1);
    check_eq("rst_Pselx", {29'd0, Pselx}, 32'd0);
    check_eq("rst_Paddr", Paddr, 32'd0);
    check_eq("rst_Pwdata", Pwdata, 32'd0);
    check_eq("rst_Hresp", {30'd0, Hresp}, 32'd0);
    @(negedge Hclk);
    Hreset = 1'b0;

    // Write 0x8000_0010 <- 0xDEADBEEF.
    cycle(2'b10, 1'b1, 1'b1, 32'h8000_0010, 32'h0, 32'h0);
    cycle(2'b00, 1'b1, 1'b0, 32'h0, 32'hDEAD_BEEF, 32'h0);
    check_eq("wr_setup_Pselx", {29'd0, Pselx}, 32'd1);
    check_eq("wr_setup_Pwrite", {31'd0, Pwrite}, 32'd1);
    check_eq("wr_setup_Penable", {31'd0, Penable}, 32'd0);
    check_eq("wr_setup_Paddr", Paddr, 32'h8000_0010);
    check_eq("wr_setup_Pwdata", Pwdata, 32'hDEAD_BEEF);
    cycle(2'b00, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0);
    check_eq("wr_enable_Penable", {31'd0, Penable}, 32'd1);
    check_eq("wr_enable_Hreadyout", {31'd0, Hreadyout}, 32'd1);

    // Back-to-back read issued during the write's ENABLE cycle.
    cycle(2'b10, 1'b1, 1'b0, 32'h8800_0000, 32'h0, 32'h0);
    check_eq("b2b_Pselx", {29'd0, Pselx}, 32'd4);
    check_eq("b2b_Hreadyout", {31'd0, Hreadyout}, 32'd0);
    cycle(2'b00, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0);

    // Read 0x8400_0004 returning 0xA5.
    cycle(2'b10, 1'b1, 1'b0, 32'h8400_0004, 32'h0, 32'hA5);
    check_eq("rd_setup_Pselx", {29'd0, Pselx}, 32'd2);
    check_eq("rd_setup_Hreadyout", {31'd0, Hreadyout}, 32'd0);
    cycle(2'b00, 1'b1, 1'b0, 32'h0, 32'h0, 32'hA5);
    check_eq("rd_enable_Hrdata", Hrdata, 32'hA5);
    check_eq("rd_enable_Hreadyout", {31'd0, Hreadyout}, 32'd1);

    // BUSY and not-ready transfers are ignored.
    cycle(2'b00, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0);
    cycle(2'b01, 1'b1, 1'b1, 32'h8000_0000, 32'h0, 32'h0);
    check_eq("busy_Pselx", {29'd0, Pselx}, 32'd0);
    check_eq("busy_Hreadyout", {31'd0, Hreadyout}, 32'd1);
    cycle(2'b10, 1'b0, 1'b0, 32'h8400_0000, 32'h0, 32'h0);
    check_eq("nordy_Pselx", {29'd0, Pselx}, 32'd0);
    check_eq("nordy_Hreadyout", {31'd0, Hreadyout}, 32'd1);

    // Unmapped address.
    cycle(2'b10, 1'b1, 1'b1, 32'h9000_0000, 32'h0, 32'h0);
`ifdef AHB_APB_ERRRESP_EN
    check_eq("err1_Hresp", {30'd0, Hresp}, 32'd1);
    check_eq("err1_Hreadyout", {31'd0, Hreadyout}, 32'd0);
    cycle(2'b00, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0);
    check_eq("err2_Hresp", {30'd0, Hresp}, 32'd1);
    check_eq("err2_Hreadyout", {31'd0, Hreadyout}, 32'd1);
`else
    check_eq("unmapped_Hresp", {30'd0, Hresp}, 32'd0);
    check_eq("unmapped_Hreadyout", {31'd0, Hreadyout}, 32'd1);
`endif
    check_eq("unmapped_Pselx", {29'd0, Pselx}, 32'd0);
    cycle(2'b00, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0);

    // Reset asserted in the middle of a write SETUP phase.
    cycle(2'b10, 1'b1, 1'b1, 32'h8000_0020, 32'h0, 32'h0);
    cycle(2'b00, 1'b1, 1'b0, 32'h0, 32'h1234_5678, 32'h0);
    check_eq("pre_rst_Pselx", {29'd0, Pselx}, 32'd1);
    Hreset = 1'b1;
    #1;
    check_eq("mid_rst_Pselx", {29'd0, Pselx}, 32'd0);
    check_eq("mid_rst_Penable", {31'd0, Penable}, 32'd0);
    check_eq("mid_rst_Hreadyout", {31'd0, Hreadyout}, 32'd1);
    model_reset();
    @(negedge Hclk);
    Hreset = 1'b0;
    cycle(2'b00, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0);

    // Random traffic.
    for (int i = 0; i < 1500; i++) begin
      case ($urandom_range(0, 7))
        0, 1:    base = 32'h8000_0000;
        2, 3:    base = 32'h8400_0000;
        4, 5:    base = 32'h8800_0000;
        default: base = $urandom & 32'hFC00_0000;
      endcase
      a = base | ($urandom & 32'h03FF_FFFF);
      cycle(2'($urandom_range(0, 3)), ($urandom_range(0, 7) != 0), 1'($urandom), a,
            $urandom, $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
